sig_gen_multi: RTL and testbench
================================

# sig_gen_multi

Multi-channel programmable test-signal generator for the frequency-meter bench. It replaces the fixed four-ratio square-wave source with CHANNELS independent PWM/square outputs. Each channel has a run-time programmable period, high time and enable, loaded through a ready/valid config port. New settings are applied glitch-free at the channel's period boundary, and each channel emits a one-cycle tick at every period start. Outputs feed the meter's signal input mux and the self-test logic.

## Interface
- CHANNELS, 2: number of independent output channels (1..8).
- CNT_W, 21: width of the period/high-time counters, in sysclk cycles.
- RST_PERIOD, 32000: period loaded into every channel at reset (3125 Hz at 100 MHz).
- RST_HIGH, 16000: high time loaded at reset. Must be < RST_PERIOD.
- RST_EN, 1: enable state loaded at reset.
- sysclk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  combinational: `~pending[cfg_chan]`.
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel. Values ≥ CHANNELS are accepted and dropped.
- cfg_period  in  CNT_W  period in cycles. Values < 2 are clamped to 2.
- cfg_high  in  CNT_W  high time in cycles. Values > period are clamped to period.
- cfg_enable  in  1  channel enable.
- sig_out  out  CHANNELS  registered generated signals.
- period_tick  out  CHANNELS  registered one-cycle pulse, asserted on the cycle the count is 0.

## Operation
- Per-channel state:
  - active regs: per_q, high_q, en_q.
  - shadow regs: per_s, high_s, en_s.
  - pending flag.
  - cnt_q (CNT_W bits).
- Accept: a write is accepted when cfg_valid & cfg_ready. The clamped values go into the shadow regs and pending is set, unless the write is applied at the same edge (see below).
- Apply conditions for accepted or pending config:
  - Immediate (next edge): active en_q=0, or en_s/cfg_enable=0.
  - Otherwise: at the wrap edge, i.e. the edge where cnt_q == per_q-1.
  - An accept coinciding with a wrap edge applies the new values at that same edge (bypass).
- On apply:
  - active ← shadow.
  - cnt_q ← 0.
  - pending ← 0.
- Count, when en_q=1: cnt_q increments, wrapping from per_q-1 to 0.
- Count, when en_q=0: cnt_q is held at 0.
- sig_out[i] is registered as en_next & (cnt_next < high_next), using the post-edge values. The output is therefore cycle-aligned with the count.
  - high=0 gives constant low.
  - high=period gives constant high.
- period_tick[i] is registered as en_next & (cnt_next == 0) & (a wrap or enabling apply occurred). It is never asserted while disabled.
- Disable: takes effect at the next edge. sig_out goes 0, cnt_q goes 0, no tick.
- Channels are fully independent. Only one config write can occur per cycle.

## Timing
- Reset (asynchronous, any time):
  - per_q=RST_PERIOD, high_q=RST_HIGH, en_q=RST_EN.
  - cnt_q=RST_PERIOD-1.
  - shadow regs = active values, pending=0.
  - sig_out=0, period_tick=0.
- First edge after reset release (RST_EN=1): cnt wraps to 0, sig_out=1, period_tick=1.
- Config latency:
  - Immediate apply: new output visible 1 edge after acceptance.
  - Boundary apply: output changes at the first wrap edge at or after acceptance. The wait is at most per_q cycles.
- cfg_ready for a channel is low from the edge after acceptance until the apply edge.
- Back-to-back writes to different channels are accepted on consecutive cycles.
- Square-wave frequency = 100 MHz / per_q. Duty = high_q / per_q.
- Reset asserted mid-period discards pending config. It is not an error.

## Test plan
- Reset defaults:
  - Stimulus: reset high for 5 cycles, release, run 64000 cycles.
  - Required response:
    - sig_out=0 and period_tick=0 during reset.
    - The first edge after release gives sig_out=1 and period_tick=1.
    - sig_out is high for exactly 16000 cycles out of every 32000.
    - period_tick pulses every 32000 cycles on each channel.
- Boundary apply:
  - Stimulus: ch0 running at 32000/16000; write period=8000, high=2000, enable=1 at cnt=100.
  - Required response:
    - cfg_ready for ch0 stays low until the wrap.
    - The old waveform completes.
    - From the wrap edge on, the output is 2000 cycles high, 6000 low, with period_tick every 8000 cycles.
- Same-cycle wrap:
  - Stimulus: write ch1 period=10, high=5 on the cycle where cnt_q=31999.
  - Required response: the next edge starts the 10-cycle period (cnt=0, sig_out=1, tick=1); pending is never set.
- Clamps and extremes:
  - Stimulus: write period=1, high=0; then period=4, high=9.
  - Required response:
    - The first write gives period 2 with constant low output.
    - The second write gives constant high output with period_tick every 4 cycles.
- Enable/disable:
  - Stimulus: write enable=0 to ch0 mid-high, then enable=1 with period=6, high=3.
  - Required response:
    - One edge after the disable: sig_out[0]=0, with no ticks.
    - One edge after the re-enable: sig_out=1 and tick=1, followed by a repeating 3-high/3-low pattern.
    - ch1 is unaffected throughout.
- Reset mid-pending:
  - Stimulus: accept a pending write to ch0, then assert reset asynchronously mid-cycle.
  - Required response: outputs go to 0 immediately; after release, the RST_PERIOD waveform runs and the pending config is never applied.

Source files
------------

// File: rtl/sig_gen_multi_if.sv
// rtl/sig_gen_multi_if.sv - configuration write port of the multi-channel signal generator
interface sig_gen_multi_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 21
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic              cfg_enable;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_period,
        output cfg_high,
        output cfg_enable,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_period,
        input  cfg_high,
        input  cfg_enable,
        output cfg_ready
    );
endinterface

// File: rtl/sig_gen_multi.sv
// rtl/sig_gen_multi.sv - CHANNELS independent PWM/square outputs with shadowed, boundary-applied config
module sig_gen_multi #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 21,
    parameter int RST_PERIOD = 32000,
    parameter int RST_HIGH   = 16000,
    parameter bit RST_EN     = 1'b1
) (
    input  logic                sysclk,
    input  logic                reset,
    sig_gen_multi_if.slave      cfg,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] period_tick
);
    localparam int               CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] RST_PER_V = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] RST_HI_V  = CNT_W'(RST_HIGH);
    localparam logic [CNT_W-1:0] MIN_PER   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0]    cfg_per_c;
    logic [CNT_W-1:0]    cfg_high_c;
    logic [CHANNELS-1:0] pend_q;

    // Clamp once at the port; every channel sees the same sanitised write.
    always_comb begin
        cfg_per_c  = (cfg.cfg_period < MIN_PER) ? MIN_PER : cfg.cfg_period;
        cfg_high_c = (cfg.cfg_high > cfg_per_c) ? cfg_per_c : cfg.cfg_high;
    end

    // Out-of-range channel numbers are always ready so the write is consumed and dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_chan == CHAN_W'(i)) begin
                cfg.cfg_ready = ~pend_q[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] per_q;
        logic [CNT_W-1:0] high_q;
        logic             en_q;
        logic [CNT_W-1:0] per_s;
        logic [CNT_W-1:0] high_s;
        logic             en_s;
        logic             pend_bit_q;
        logic [CNT_W-1:0] cnt_q;
        logic             sig_q;
        logic             tick_q;

        logic             acc;
        logic             wrap;
        logic             apply;
        logic [CNT_W-1:0] cand_per;
        logic [CNT_W-1:0] cand_high;
        logic             cand_en;
        logic [CNT_W-1:0] per_d;
        logic [CNT_W-1:0] high_d;
        logic             en_d;
        logic [CNT_W-1:0] per_sd;
        logic [CNT_W-1:0] high_sd;
        logic             en_sd;
        logic             pend_d;
        logic [CNT_W-1:0] cnt_d;
        logic             sig_d;
        logic             tick_d;

        always_comb begin
            acc       = cfg.cfg_valid && (cfg.cfg_chan == CHAN_W'(g)) && !pend_bit_q;
            wrap      = en_q && (cnt_q == (per_q - ONE));
            // A fresh write bypasses the shadow so it can land on this very edge.
            cand_per  = acc ? cfg_per_c  : per_s;
            cand_high = acc ? cfg_high_c : high_s;
            cand_en   = acc ? cfg.cfg_enable : en_s;
            apply     = (acc || pend_bit_q) && (!en_q || !cand_en || wrap);

            per_d   = per_q;
            high_d  = high_q;
            en_d    = en_q;
            per_sd  = per_s;
            high_sd = high_s;
            en_sd   = en_s;
            pend_d  = pend_bit_q;
            cnt_d   = cnt_q;

            if (apply) begin
                per_d   = cand_per;
                high_d  = cand_high;
                en_d    = cand_en;
                per_sd  = cand_per;
                high_sd = cand_high;
                en_sd   = cand_en;
                pend_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                if (acc) begin
                    per_sd  = cand_per;
                    high_sd = cand_high;
                    en_sd   = cand_en;
                    pend_d  = 1'b1;
                end
                if (!en_q || wrap) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            // Outputs are computed from post-edge state so they line up with cnt_q.
            sig_d  = en_d && (cnt_d < high_d);
            tick_d = en_d && (cnt_d == '0) && (wrap || apply);
        end

        always_ff @(posedge sysclk or posedge reset) begin
            if (reset) begin
                per_q      <= RST_PER_V;
                high_q     <= RST_HI_V;
                en_q       <= RST_EN;
                per_s      <= RST_PER_V;
                high_s     <= RST_HI_V;
                en_s       <= RST_EN;
                pend_bit_q <= 1'b0;
                cnt_q      <= RST_PER_V - ONE;
                sig_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                per_q      <= per_d;
                high_q     <= high_d;
                en_q       <= en_d;
                per_s      <= per_sd;
                high_s     <= high_sd;
                en_s       <= en_sd;
                pend_bit_q <= pend_d;
                cnt_q      <= cnt_d;
                sig_q      <= sig_d;
                tick_q     <= tick_d;
            end
        end

        assign pend_q[g]      = pend_bit_q;
        assign sig_out[g]     = sig_q;
        assign period_tick[g] = tick_q;
    end
endmodule

// File: tb/tb_sig_gen_multi.sv
// tb/tb_sig_gen_multi.sv - self-checking bench for sig_gen_multi
module tb_sig_gen_multi;
    localparam int CH = 2;
    localparam int CW = 21;
    localparam int RP = 32000;
    localparam int RH = 16000;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b0;
    logic [CH-1:0] sig_out;
    logic [CH-1:0] period_tick;

    sig_gen_multi_if #(.CHANNELS(CH), .CNT_W(CW)) cfg_if ();

    sig_gen_multi #(
        .CHANNELS(CH), .CNT_W(CW), .RST_PERIOD(RP), .RST_HIGH(RH), .RST_EN(1'b1)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .cfg(cfg_if),
        .sig_out(sig_out),
        .period_tick(period_tick)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [CH-1:0] sig;
        logic [CH-1:0] tick;
    } exp_t;
    exp_t sb[$];

    int m_per[CH];
    int m_high[CH];
    int m_cnt[CH];
    int m_sper[CH];
    int m_shigh[CH];
    bit m_en[CH];
    bit m_sen[CH];
    bit m_pend[CH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_per[i]   = RP;
            m_high[i]  = RH;
            m_en[i]    = 1'b1;
            m_cnt[i]   = RP - 1;
            m_sper[i]  = RP;
            m_shigh[i] = RH;
            m_sen[i]   = 1'b1;
            m_pend[i]  = 1'b0;
        end
    endtask

    // One clock: predict from current inputs, queue the prediction, compare after the edge.
    task automatic step();
        exp_t e;
        bit   hit, wrap, go;
        int   p, h;
        #1;
        check("cfg_ready", cfg_if.cfg_ready, !m_pend[int'(cfg_if.cfg_chan)]);
        e = '0;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                hit = cfg_if.cfg_valid && (int'(cfg_if.cfg_chan) == i) && !m_pend[i];
                if (hit) begin
                    p = (int'(cfg_if.cfg_period) < 2) ? 2 : int'(cfg_if.cfg_period);
                    h = (int'(cfg_if.cfg_high) > p) ? p : int'(cfg_if.cfg_high);
                    m_sper[i]  = p;
                    m_shigh[i] = h;
                    m_sen[i]   = cfg_if.cfg_enable;
                    m_pend[i]  = 1'b1;
                end
                wrap = m_en[i] && (m_cnt[i] == m_per[i] - 1);
                go   = m_pend[i] && (!m_en[i] || !m_sen[i] || wrap);
                if (go) begin
                    m_per[i]  = m_sper[i];
                    m_high[i] = m_shigh[i];
                    m_en[i]   = m_sen[i];
                    m_cnt[i]  = 0;
                    m_pend[i] = 1'b0;
                end else if (!m_en[i] || wrap) begin
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                e.sig[i]  = m_en[i] && (m_cnt[i] < m_high[i]);
                e.tick[i] = m_en[i] && (go || wrap);
            end
        end
        sb.push_back(e);
        @(posedge sysclk);
        #1;
        e = sb.pop_front();
        check("sig_out", sig_out, e.sig);
        check("period_tick", period_tick, e.tick);
    endtask

    task automatic drive_cfg(input int ch, input int p, input int h, input bit en);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_chan   = ch[0];
        cfg_if.cfg_period = CW'(p);
        cfg_if.cfg_high   = CW'(h);
        cfg_if.cfg_enable = en;
    endtask

    task automatic idle();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int hi[CH];
        int last[CH];
        int s0, t0, s1, t1;

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_chan   = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_high   = '0;
        cfg_if.cfg_enable = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        repeat (5) step();
        check("rst_sig", sig_out, 0);
        check("rst_tick", period_tick, 0);
        reset = 1'b0;

        // Reset defaults, with the ch0 boundary write landing mid second period.
        for (int c = 0; c < CH; c++) begin
            hi[c]   = 0;
            last[c] = 0;
        end
        for (int k = 1; k <= 64000; k++) begin
            if (k == 32102) drive_cfg(0, 8000, 2000, 1'b1);
            else idle();
            step();
            if (k == 1) begin
                check("first_sig", sig_out, 2'b11);
                check("first_tick", period_tick, 2'b11);
            end
            for (int c = 0; c < CH; c++) begin
                hi[c] += int'(sig_out[c]);
                if (period_tick[c]) begin
                    if (last[c] != 0) check("tick_gap_rst", k - last[c], RP);
                    last[c] = k;
                end
            end
            if (k == 32000 || k == 64000) begin
                check("duty_ch0", hi[0], RH);
                check("duty_ch1", hi[1], RH);
                hi[0] = 0;
                hi[1] = 0;
            end
            if (k == 32102 || k == 64000) check("ready_hold_ch0", cfg_if.cfg_ready, 0);
        end

        // Same-cycle wrap on ch1 while ch0's pending write also applies.
        drive_cfg(1, 10, 5, 1'b1);
        step();
        check("wrap_sig", sig_out, 2'b11);
        check("wrap_tick", period_tick, 2'b11);
        check("bypass_ready_ch1", cfg_if.cfg_ready, 1);
        idle();

        // ch0 new 8000/2000 period, clamp tests on ch1 in parallel.
        hi[0]   = 1;
        last[0] = 64001;
        s1 = 0;
        t1 = 0;
        for (int k = 64002; k <= 73001; k++) begin
            if (k == 64021) drive_cfg(1, 1, 0, 1'b1);
            else if (k == 64050) drive_cfg(1, 4, 9, 1'b1);
            else idle();
            step();
            if (k <= 72000) hi[0] += int'(sig_out[0]);
            if (k == 72000) check("duty_8000", hi[0], 2000);
            if (period_tick[0]) begin
                check("tick_gap_8000", k - last[0], 8000);
                last[0] = k;
            end
            if (k == 64050) check("clamp_pend_ready", cfg_if.cfg_ready, 0);
            if (k >= 64030 && k <= 64039) begin
                s1 += int'(sig_out[1]);
                t1 += int'(period_tick[1]);
            end
            if (k == 64039) begin
                check("clamp_low_sig", s1, 0);
                check("clamp_p2_ticks", t1, 5);
                s1 = 0;
                t1 = 0;
            end
            if (k >= 64060 && k <= 64075) begin
                s1 += int'(sig_out[1]);
                t1 += int'(period_tick[1]);
            end
            if (k == 64075) begin
                check("clamp_high_sig", s1, 16);
                check("clamp_p4_ticks", t1, 4);
            end
        end
        check("ch0_last_tick", last[0], 72001);
        check("pre_dis_sig0", sig_out[0], 1);

        // Disable ch0 mid-high, then re-enable at 6/3.
        drive_cfg(0, 6, 3, 1'b0);
        step();
        idle();
        check("dis_sig0", sig_out[0], 0);
        check("dis_tick0", period_tick[0], 0);
        s0 = 0; t0 = 0; s1 = 0;
        repeat (10) begin
            step();
            s0 += int'(sig_out[0]);
            t0 += int'(period_tick[0]);
            s1 += int'(sig_out[1]);
        end
        check("dis_quiet_sig0", s0, 0);
        check("dis_quiet_tick0", t0, 0);
        check("ch1_unaffected", s1, 10);

        drive_cfg(0, 6, 3, 1'b1);
        step();
        idle();
        check("en_sig0", sig_out[0], 1);
        check("en_tick0", period_tick[0], 1);
        for (int j = 1; j <= 12; j++) begin
            step();
            check("pat_sig0", sig_out[0], (j % 6) < 3);
            check("pat_tick0", period_tick[0], (j % 6) == 0);
        end

        // Pending write discarded by a mid-cycle reset.
        drive_cfg(0, 8000, 100, 1'b1);
        step();
        idle();
        check("pend_ready_ch0", cfg_if.cfg_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sig", sig_out, 0);
        check("async_rst_tick", period_tick, 0);
        model_reset();
        sb.delete();
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rerst_sig", sig_out, 2'b11);
        check("rerst_tick", period_tick, 2'b11);
        check("rerst_ready", cfg_if.cfg_ready, 1);
        s0 = 0; t0 = 0;
        repeat (200) begin
            step();
            s0 += int'(sig_out[0]);
            t0 += int'(period_tick[0]);
        end
        check("no_stale_sig0", s0, 200);
        check("no_stale_tick0", t0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
